// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage (lw, sw, R-ALU, I-ALU, beq, jal) with register file and D/E pipeline register.
// Latency: 1 cycle. Fields decoded from InstrD at edge N appear on the *E outputs after edge N.
// Backpressure: none. The D/E register loads every cycle. FlushE loads a bubble, and rst clears the stage and the register file.
//
// Ports:
//   clk, rst                  clock; synchronous active-high reset
//   InstrD, PCD, PCPlus4D     instruction and PCs from fetch
//   RegWriteW, RDW, ResultW   writeback port into the register file
//   FlushE                    insert a bubble into the E stage
//   Rs1D, Rs2D                combinational source indices for the hazard unit
//   *E outputs                registered control, operands, immediate, indices, PCs
module decode_cycle #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic            ALUSrcE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      RdE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_J} imm_src_t;
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;

  assign opcode   = InstrD[6:0];
  assign funct3   = InstrD[14:12];
  assign funct7b5 = InstrD[30];
  assign Rs1D     = InstrD[19:15];
  assign Rs2D     = InstrD[24:20];

  // Main control decode
  logic       reg_write, alu_src, mem_write, branch, jump;
  logic [1:0] result_src;
  imm_src_t   imm_src;
  alu_op_t    alu_op;

  always_comb begin
    reg_write  = 1'b0;
    imm_src    = IMM_NONE;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 2'b00;
    branch     = 1'b0;
    alu_op     = ALUOP_ADD;
    jump       = 1'b0;
    case (opcode)
      OP_LW: begin
        reg_write  = 1'b1;
        imm_src    = IMM_I;
        alu_src    = 1'b1;
        result_src = 2'b01;
      end
      OP_SW: begin
        imm_src   = IMM_S;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_IALU: begin
        reg_write = 1'b1;
        imm_src   = IMM_I;
        alu_src   = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_BEQ: begin
        imm_src = IMM_B;
        branch  = 1'b1;
        alu_op  = ALUOP_SUB;
      end
      OP_JAL: begin
        reg_write  = 1'b1;
        imm_src    = IMM_J;
        result_src = 2'b10;
        jump       = 1'b1;
      end
      default: ; // unknown opcode decodes as a bubble
    endcase
  end

  // ALU control. funct7[5] selects sub only for R-type; for I-type that bit belongs to the immediate.
  logic [2:0] alu_control;

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // Immediate generation
  logic [XLEN-1:0] imm_ext;

  always_comb begin
    imm_ext = '0;
    case (imm_src)
      IMM_I: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      IMM_S: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B: imm_ext = {{(XLEN-13){InstrD[31]}}, InstrD[31], InstrD[7],
                        InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J: imm_ext = {{(XLEN-21){InstrD[31]}}, InstrD[31], InstrD[19:12],
                        InstrD[20], InstrD[30:21], 1'b0};
      default: imm_ext = '0;
    endcase
  end

  // Register file. Entry 0 is never written and is masked on read.
  logic [XLEN-1:0] rf [NREGS];
  logic            wb_en;
  logic [XLEN-1:0] rd1, rd2;

  assign wb_en = RegWriteW && (RDW != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_en) begin
      rf[RDW] <= ResultW;
    end
  end

  // Write-first bypass: same-cycle writeback is visible to the reads.
  always_comb begin
    rd1 = '0;
    if (Rs1D != 5'd0) rd1 = (wb_en && RDW == Rs1D) ? ResultW : rf[Rs1D];
  end

  always_comb begin
    rd2 = '0;
    if (Rs2D != 5'd0) rd2 = (wb_en && RDW == Rs2D) ? ResultW : rf[Rs2D];
  end

  // D/E pipeline register
  always_ff @(posedge clk) begin
    if (rst || FlushE) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= 2'b00;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= 3'b000;
      ALUSrcE     <= 1'b0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      RdE         <= 5'd0;
      Rs1E        <= 5'd0;
      Rs2E        <= 5'd0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else begin
      RegWriteE   <= reg_write;
      ResultSrcE  <= result_src;
      MemWriteE   <= mem_write;
      JumpE       <= jump;
      BranchE     <= branch;
      ALUControlE <= alu_control;
      ALUSrcE     <= alu_src;
      RD1E        <= rd1;
      RD2E        <= rd2;
      ImmExtE     <= imm_ext;
      RdE         <= InstrD[11:7];
      Rs1E        <= Rs1D;
      Rs2E        <= Rs2D;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed vectors for decode_cycle with hand-computed expectations.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: none; inputs are driven right after each sample point.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        RegWriteW, FlushE;
  logic [4:0]  RDW;
  logic [4:0]  Rs1D, Rs2D, RdE, Rs1E, Rs2E;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;

  int vectors = 0;
  int miscompares = 0;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .PCE(PCE),
    .PCPlus4E(PCPlus4E)
  );

  always #5 clk = ~clk;

  // Control bundle: {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc}
  function automatic logic [9:0] ctl(input logic rw, input logic [1:0] rs, input logic mw,
                                     input logic j, input logic b, input logic [2:0] alu,
                                     input logic as);
    return {rw, rs, mw, j, b, alu, as};
  endfunction

  logic [9:0] ctrl_e;
  assign ctrl_e = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; FlushE = 1'b0; InstrD = 32'h0000_0013; PCD = 32'h4; PCPlus4D = 32'h8;
    RegWriteW = 1'b0; RDW = 5'd0; ResultW = 32'h0;

    // Reset for two edges
    step();
    chk("rst1_ctrl", 32'(ctrl_e), 32'h0);
    chk("rst1_imm", ImmExtE, 32'h0);
    chk("rst1_pce", PCE, 32'h0);
    step();
    chk("rst2_ctrl", 32'(ctrl_e), 32'h0);
    chk("rst2_pc4", PCPlus4E, 32'h0);
    rst = 1'b0;
    step();
    chk("nop_ctrl", 32'(ctrl_e), 32'(ctl(1, 2'b00, 0, 0, 0, 3'b000, 1)));
    chk("nop_imm", ImmExtE, 32'h0);

    // addi x1,x0,5
    InstrD = 32'h0050_0093; PCD = 32'h10; PCPlus4D = 32'h14;
    #1;
    chk("addi_rs2d", 32'(Rs2D), 32'd5);
    step();
    chk("addi_ctrl", 32'(ctrl_e), 32'(ctl(1, 2'b00, 0, 0, 0, 3'b000, 1)));
    chk("addi_imm", ImmExtE, 32'd5);
    chk("addi_rd", 32'(RdE), 32'd1);
    chk("addi_pce", PCE, 32'h10);
    chk("addi_pc4", PCPlus4E, 32'h14);

    // add x2,x1,x1 while x1<=5 is written back in the same cycle
    RegWriteW = 1'b1; RDW = 5'd1; ResultW = 32'd5; InstrD = 32'h0010_8133;
    step();
    chk("byp_rd1", RD1E, 32'd5);
    chk("byp_rd2", RD2E, 32'd5);
    chk("byp_rs1e", 32'(Rs1E), 32'd1);
    chk("byp_rde", 32'(RdE), 32'd2);
    chk("byp_ctrl", 32'(ctrl_e), 32'(ctl(1, 2'b00, 0, 0, 0, 3'b000, 0)));

    // add x2,x0,x1 while writing x0: x0 reads 0, x1 comes from the array
    RDW = 5'd0; ResultW = 32'h55; InstrD = 32'h0010_0133;
    step();
    chk("x0_rd1", RD1E, 32'h0);
    chk("x1_rd2", RD2E, 32'd5);
    RegWriteW = 1'b0;

    // sw x2,8(x0)
    InstrD = 32'h0020_2423;
    step();
    chk("sw_ctrl", 32'(ctrl_e), 32'(ctl(0, 2'b00, 1, 0, 0, 3'b000, 1)));
    chk("sw_imm", ImmExtE, 32'd8);

    // beq x0,x0,-4
    InstrD = 32'hFE00_0EE3;
    step();
    chk("beq_ctrl", 32'(ctrl_e), 32'(ctl(0, 2'b00, 0, 0, 1, 3'b001, 0)));
    chk("beq_imm", ImmExtE, 32'hFFFF_FFFC);

    // jal x1,8
    InstrD = 32'h0080_00EF;
    step();
    chk("jal_ctrl", 32'(ctrl_e), 32'(ctl(1, 2'b10, 0, 1, 0, 3'b000, 0)));
    chk("jal_imm", ImmExtE, 32'd8);
    chk("jal_rd", 32'(RdE), 32'd1);

    // sub x5,x1,x2
    InstrD = 32'h4020_82B3;
    step();
    chk("sub_ctrl", 32'(ctrl_e), 32'(ctl(1, 2'b00, 0, 0, 0, 3'b001, 0)));
    chk("sub_imm", ImmExtE, 32'h0);

    // addi x1,x0,1024: bit 30 set must not turn an I-type into sub
    InstrD = 32'h4000_0093;
    step();
    chk("addi400_ctrl", 32'(ctrl_e), 32'(ctl(1, 2'b00, 0, 0, 0, 3'b000, 1)));
    chk("addi400_imm", ImmExtE, 32'h400);

    // andi x6,x1,-1
    InstrD = 32'hFFF0_F313;
    step();
    chk("andi_ctrl", 32'(ctrl_e), 32'(ctl(1, 2'b00, 0, 0, 0, 3'b010, 1)));
    chk("andi_imm", ImmExtE, 32'hFFFF_FFFF);

    // lw x7,-8(x2): funct3=010 must stay add
    InstrD = 32'hFF81_2383;
    step();
    chk("lw_ctrl", 32'(ctrl_e), 32'(ctl(1, 2'b01, 0, 0, 0, 3'b000, 1)));
    chk("lw_imm", ImmExtE, 32'hFFFF_FFF8);

    // slti x2,x1,5
    InstrD = 32'h0050_A113;
    step();
    chk("slti_ctrl", 32'(ctrl_e), 32'(ctl(1, 2'b00, 0, 0, 0, 3'b101, 1)));
    chk("slti_rd1", RD1E, 32'd5);

    // ori x2,x1,3
    InstrD = 32'h0030_E113;
    step();
    chk("ori_ctrl", 32'(ctrl_e), 32'(ctl(1, 2'b00, 0, 0, 0, 3'b011, 1)));
    chk("ori_imm", ImmExtE, 32'd3);

    // Flush with sw on InstrD
    InstrD = 32'h0020_2423; PCD = 32'h20; PCPlus4D = 32'h24; FlushE = 1'b1;
    step();
    chk("flush_ctrl", 32'(ctrl_e), 32'h0);
    chk("flush_imm", ImmExtE, 32'h0);
    chk("flush_pce", PCE, 32'h0);

    // Flush together with reset
    rst = 1'b1;
    step();
    chk("flushrst_ctrl", 32'(ctrl_e), 32'h0);
    chk("flushrst_pc4", PCPlus4E, 32'h0);
    rst = 1'b0; FlushE = 1'b0;

    // Write x3=0xDEAD, then read it with add x4,x3,x0
    RegWriteW = 1'b1; RDW = 5'd3; ResultW = 32'hDEAD; InstrD = 32'h0000_0013;
    step();
    RegWriteW = 1'b0; InstrD = 32'h0001_8233;
    step();
    chk("x3_written", RD1E, 32'hDEAD);

    // Reset mid-operation with a concurrent writeback that must be discarded
    rst = 1'b1; RegWriteW = 1'b1; RDW = 5'd3; ResultW = 32'hBEEF;
    step();
    chk("midrst_rd1", RD1E, 32'h0);
    rst = 1'b0; RegWriteW = 1'b0;
    step();
    chk("x3_cleared", RD1E, 32'h0);
    chk("x3_rd_ctrl", 32'(ctrl_e), 32'(ctl(1, 2'b00, 0, 0, 0, 3'b000, 0)));

    // Illegal opcode
    InstrD = 32'h0000_007F;
    step();
    chk("illegal_ctrl", 32'(ctrl_e), 32'h0);
    chk("illegal_imm", ImmExtE, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
